// File: rtl/ysyx_22041071_mul_ctrl_pkg.sv
// Shared encodings for the multiplier controller: op codes, FSM states and result-select helper.
// Optional zero-operand bypass is enabled by defining YSYX_22041071_MUL_ZERO_BYPASS_EN.
package ysyx_22041071_mul_ctrl_pkg;

  localparam int MUL_XLEN_DEF = 64;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_BUSY = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_e;

  typedef enum logic [1:0] {
    RES_SEL_LO = 2'd0,
    RES_SEL_HI = 2'd1,
    RES_SEL_W  = 2'd2
  } res_sel_e;

  // A word op always takes the sign-extended low word, whatever mul_op says.
  function automatic res_sel_e res_sel_of(input logic [1:0] op, input logic w);
    res_sel_e sel;
    if (w)
      sel = RES_SEL_W;
    else if (op == MUL_OP_MUL)
      sel = RES_SEL_LO;
    else
      sel = RES_SEL_HI;
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_22041071_mul_opfmt.sv
// Combinational operand formatter: sign/zero-extends both sources to XLEN+2 bits,
// or sign-extends the low words for MULW.
module ysyx_22041071_mul_opfmt
  import ysyx_22041071_mul_ctrl_pkg::*;
#(
  parameter int XLEN = MUL_XLEN_DEF
) (
  input  logic [1:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN+1:0] x,
  output logic [XLEN+1:0] y
);

  logic x_signed;
  logic y_signed;

  assign x_signed = (op != MUL_OP_MULHU);
  assign y_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);

  always_comb begin
    x = '0;
    y = '0;
    if (w) begin
      x = {{(XLEN-30){src1[31]}}, src1[31:0]};
      y = {{(XLEN-30){src2[31]}}, src2[31:0]};
    end else begin
      x = {{2{x_signed & src1[XLEN-1]}}, src1};
      y = {{2{y_signed & src2[XLEN-1]}}, src2};
    end
  end

endmodule

// File: rtl/ysyx_22041071_mul_ctrl.sv
// Sequencing controller for the multi-cycle multiplier datapath: accept, launch, wait DP_LAT, select, hand off.
// Define YSYX_22041071_MUL_ZERO_BYPASS_EN to short-circuit zero operands straight to DONE.
module ysyx_22041071_mul_ctrl
  import ysyx_22041071_mul_ctrl_pkg::*;
#(
  parameter int XLEN   = MUL_XLEN_DEF,
  parameter int DP_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [1:0]      mul_op,
  input  logic            mul_w,
  input  logic [XLEN-1:0] mul_src1,
  input  logic [XLEN-1:0] mul_src2,
  output logic            dp_start,
  output logic [XLEN+1:0] dp_x,
  output logic [XLEN+1:0] dp_y,
  input  logic [XLEN-1:0] dp_prod_hi,
  input  logic [XLEN-1:0] dp_prod_lo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = (DP_LAT < 1) ? 1 : $clog2(DP_LAT + 1);

  mul_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  res_sel_e        sel_reg;
  logic            dp_start_reg;
  logic [XLEN+1:0] dp_x_reg, dp_y_reg;
  logic            out_valid_reg;
  logic [XLEN-1:0] out_result_reg;

  logic [XLEN+1:0] fmt_x, fmt_y;
  logic            accept;
  logic            lat_done;
  logic            out_fire;
  logic            fmt_zero;
  logic [XLEN-1:0] result_next;

  ysyx_22041071_mul_opfmt #(.XLEN(XLEN)) u_opfmt (
    .op   (mul_op),
    .w    (mul_w),
    .src1 (mul_src1),
    .src2 (mul_src2),
    .x    (fmt_x),
    .y    (fmt_y)
  );

`ifdef YSYX_22041071_MUL_ZERO_BYPASS_EN
  assign fmt_zero = (fmt_x == '0) || (fmt_y == '0);
`else
  assign fmt_zero = 1'b0;
`endif

  assign mul_ready = (state_reg == MUL_ST_IDLE) && !flush;
  assign accept    = mul_valid && mul_ready;
  // Counter reaches DP_LAT in the cycle the datapath product is valid.
  assign lat_done  = (state_reg == MUL_ST_BUSY) && (cnt_reg == CNT_W'(DP_LAT));
  assign out_fire  = out_valid_reg && out_ready;

  always_comb begin
    result_next = dp_prod_hi;
    case (sel_reg)
      RES_SEL_LO: result_next = dp_prod_lo;
      RES_SEL_HI: result_next = dp_prod_hi;
      RES_SEL_W:  result_next = {{(XLEN-32){dp_prod_lo[31]}}, dp_prod_lo[31:0]};
      default:    result_next = dp_prod_hi;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = MUL_ST_IDLE;
    end else begin
      case (state_reg)
        MUL_ST_IDLE: if (accept) state_next = fmt_zero ? MUL_ST_DONE : MUL_ST_BUSY;
        MUL_ST_BUSY: if (lat_done) state_next = MUL_ST_DONE;
        MUL_ST_DONE: if (out_fire) state_next = MUL_ST_IDLE;
        default:     state_next = MUL_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= MUL_ST_IDLE;
      cnt_reg        <= '0;
      sel_reg        <= RES_SEL_LO;
      dp_start_reg   <= 1'b0;
      dp_x_reg       <= '0;
      dp_y_reg       <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
    end else begin
      state_reg    <= state_next;
      dp_start_reg <= accept && !fmt_zero;

      if (accept) begin
        dp_x_reg <= fmt_x;
        dp_y_reg <= fmt_y;
        sel_reg  <= res_sel_of(mul_op, mul_w);
      end

      if (flush || accept)
        cnt_reg <= '0;
      else if ((state_reg == MUL_ST_BUSY) && !lat_done)
        cnt_reg <= cnt_reg + 1'b1;

      // out_result survives flush; only a fresh completion or reset replaces it.
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (lat_done) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= result_next;
      end else if (accept && fmt_zero) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= '0;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign dp_start   = dp_start_reg;
  assign dp_x       = dp_x_reg;
  assign dp_y       = dp_y_reg;
  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;

endmodule

// File: tb/tb_ysyx_22041071_mul_ctrl.sv
// Self-checking bench for ysyx_22041071_mul_ctrl with a behavioural 66x66 datapath of latency DP_LAT.
// Honours YSYX_22041071_MUL_ZERO_BYPASS_EN when the DUT is built with it.
module tb_ysyx_22041071_mul_ctrl;

  localparam int XLEN   = 64;
  localparam int DP_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              mul_valid = 1'b0;
  logic              mul_ready;
  logic [1:0]        mul_op = 2'b00;
  logic              mul_w = 1'b0;
  logic [XLEN-1:0]   mul_src1 = '0;
  logic [XLEN-1:0]   mul_src2 = '0;
  logic              dp_start;
  logic [XLEN+1:0]   dp_x, dp_y;
  logic [XLEN-1:0]   dp_prod_hi = '0;
  logic [XLEN-1:0]   dp_prod_lo = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dp_cnt   = 0;
  int dp_start_cnt = 0;
  logic [127:0] dp_p = '0;

  ysyx_22041071_mul_ctrl #(.XLEN(XLEN), .DP_LAT(DP_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .mul_op     (mul_op),
    .mul_w      (mul_w),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .dp_start   (dp_start),
    .dp_x       (dp_x),
    .dp_y       (dp_y),
    .dp_prod_hi (dp_prod_hi),
    .dp_prod_lo (dp_prod_lo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dp_start) dp_start_cnt <= dp_start_cnt + 1;
  end

  function automatic logic [127:0] dp_mult(input logic [65:0] x, input logic [65:0] y);
    logic signed [131:0] a, b, p;
    a = $signed(x);
    b = $signed(y);
    p = a * b;
    return p[127:0];
  endfunction

  // Datapath: product only valid in the single cycle DP_LAT after the launch cycle.
  always @(negedge clk) begin
    dp_prod_hi <= {$urandom, $urandom};
    dp_prod_lo <= {$urandom, $urandom};
    if (dp_cnt == 1) begin
      dp_prod_hi <= dp_p[127:64];
      dp_prod_lo <= dp_p[63:0];
    end
    if (dp_start) begin
      dp_cnt <= DP_LAT;
      dp_p   <= dp_mult(dp_x, dp_y);
    end else if (dp_cnt != 0) begin
      dp_cnt <= dp_cnt - 1;
    end
  end

  // Architectural RV64M result from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                             input logic [63:0] s1, input logic [63:0] s2);
    logic signed [129:0] a, b, p;
    int     a32, b32;
    longint pw;
    logic [63:0] r;
    if (w) begin
      a32 = s1[31:0];
      b32 = s2[31:0];
      pw  = longint'(a32) * longint'(b32);
      r   = {{32{pw[31]}}, pw[31:0]};
    end else begin
      if (op == 2'b11) a = {66'b0, s1};
      else             a = $signed(s1);
      if (op == 2'b00 || op == 2'b01) b = $signed(s2);
      else                            b = {66'b0, s2};
      p = a * b;
      r = (op == 2'b00) ? p[63:0] : p[127:64];
    end
    return r;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] s1,
                        input logic [63:0] s2, input int hold,
                        output logic [63:0] res, output int lat, output int acc_cyc);
    int waitc;
    logic [63:0] exp;
    waitc = 0;
    while (!mul_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    n_checks++;
    if (mul_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: mul_ready=%b required 1", mul_ready);
    end
    mul_op = op; mul_w = w; mul_src1 = s1; mul_src2 = s2; mul_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    mul_valid = 1'b0;
    mul_op = 2'($urandom);
    mul_w = 1'($urandom);
    mul_src1 = {$urandom, $urandom};
    mul_src2 = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp = ref_result(op, w, s1, s2);
    res = out_result;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1 within 40 cycles", out_valid);
    end
    n_checks++;
    if (out_result !== exp) begin
      n_fail++;
      $display("FAIL result op=%0d w=%0d: got %h required %h", op, w, out_result, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== res || mul_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b result=%h ready=%b required 1 %h 0",
                 out_valid, out_result, mul_ready, res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_drop: out_valid=%b required 0 after handshake", out_valid);
    end
    $display("op=%0d w=%0d src1=%h src2=%h result=%h lat=%0d hold=%0d", op, w, s1, s2, res, lat, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || dp_start !== 1'b0 ||
        dp_x !== 66'd0 || dp_y !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b result=%h start=%b x=%h y=%h required all 0",
               out_valid, out_result, dp_start, dp_x, dp_y);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mul_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: mul_ready=%b required 1", mul_ready);
    end
  endtask

  task automatic test_mul_basic();
    logic [63:0] res;
    int lat, acc;
    logic [65:0] ex;
    run_op(2'b00, 1'b0, 64'd3, 64'd5, 0, res, lat, acc);
    n_checks++;
    if (res !== 64'd15) begin
      n_fail++;
      $display("FAIL mul_3x5: got %0d required 15", res);
    end
    n_checks++;
    if (lat != DP_LAT + 2) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d required %0d", lat, DP_LAT + 2);
    end
    ex = 66'd3;
    n_checks++;
    if (dp_x !== ex || dp_y !== 66'd5) begin
      n_fail++;
      $display("FAIL mul_operands: x=%h y=%h required 3 5", dp_x, dp_y);
    end
  endtask

  task automatic test_mulh_variants();
    logic [63:0] res, exp;
    int lat, acc;
    logic [63:0] ones;
    logic [65:0] ex;
    ones = '1;
    for (int k = 1; k < 4; k++) begin
      case (k)
        1: exp = 64'h0;
        2: exp = 64'hFFFF_FFFF_FFFF_FFFF;
        default: exp = 64'hFFFF_FFFF_FFFF_FFFE;
      endcase
      run_op(2'(k), 1'b0, ones, ones, 0, res, lat, acc);
      n_checks++;
      if (res !== exp) begin
        n_fail++;
        $display("FAIL mulh_all_ones op=%0d: got %h required %h", k, res, exp);
      end
    end
    ex = {2'b00, ones};
    n_checks++;
    if (dp_x !== ex || dp_y !== ex) begin
      n_fail++;
      $display("FAIL mulhu_zext: x=%h y=%h required %h", dp_x, dp_y, ex);
    end
  endtask

  task automatic test_mulw();
    logic [63:0] res;
    int lat, acc;
    run_op(2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 0, res, lat, acc);
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL mulw: got %h required fffffffffffffffe", res);
    end
    run_op(2'b11, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 0, res, lat, acc);
    n_checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL mulw_garbage_upper: got %h required fffffffffffffffe", res);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    int lat, acc;
    run_op(2'b00, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 4, res, lat, acc);
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat, acc, starts;
    while (!mul_ready) @(negedge clk);
    mul_op = 2'b00; mul_w = 1'b0; mul_src1 = 64'd9; mul_src2 = 64'd9; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || mul_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: valid=%b ready=%b required 0 1", out_valid, mul_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_valid cycle %0d: out_valid=%b required 0", i, out_valid);
      end
    end
    flush = 1'b1; mul_valid = 1'b1; mul_src1 = 64'd1; mul_src2 = 64'd1;
    #1;
    n_checks++;
    if (mul_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_ready: mul_ready=%b required 0", mul_ready);
    end
    starts = dp_start_cnt;
    @(negedge clk);
    mul_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dp_start_cnt != starts || out_valid !== 1'b0 || mul_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_no_accept: starts=%0d valid=%b ready=%b required %0d 0 1",
               dp_start_cnt, out_valid, mul_ready, starts);
    end
    run_op(2'b00, 1'b0, 64'd7, 64'd6, 0, res, lat, acc);
    n_checks++;
    if (res !== 64'd42) begin
      n_fail++;
      $display("FAIL flush_then_mul: got %0d required 42", res);
    end
  endtask

  task automatic test_rst_mid();
    logic [63:0] res;
    int lat, acc;
    run_op(2'b00, 1'b0, 64'd3, 64'd5, 0, res, lat, acc);
    mul_op = 2'b00; mul_w = 1'b0; mul_src1 = 64'd11; mul_src2 = 64'd13; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || dp_start !== 1'b0 ||
        dp_x !== 66'd0 || dp_y !== 66'd0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b result=%h start=%b x=%h y=%h required all 0",
               out_valid, out_result, dp_start, dp_x, dp_y);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_discard cycle %0d: out_valid=%b required 0", i, out_valid);
      end
    end
    run_op(2'b00, 1'b0, 64'h1234, 64'h10, 0, res, lat, acc);
  endtask

  task automatic test_zero();
    logic [63:0] res;
    int lat, acc, starts, exp_lat, exp_starts;
`ifdef YSYX_22041071_MUL_ZERO_BYPASS_EN
    exp_lat = 1; exp_starts = 0;
`else
    exp_lat = DP_LAT + 2; exp_starts = 1;
`endif
    starts = dp_start_cnt;
    run_op(2'b00, 1'b0, 64'd0, 64'h55, 0, res, lat, acc);
    n_checks++;
    if (res !== 64'd0 || lat != exp_lat || (dp_start_cnt - starts) != exp_starts) begin
      n_fail++;
      $display("FAIL zero_operand: res=%h lat=%0d starts=%0d required 0 %0d %0d",
               res, lat, dp_start_cnt - starts, exp_lat, exp_starts);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, acc1, acc2;
    run_op(2'b01, 1'b0, 64'h8000_0000_0000_0001, 64'd3, 0, res, lat, acc1);
    run_op(2'b10, 1'b0, 64'hFFFF_FFFF_0000_0007, 64'h9000_0000_0000_0000, 0, res, lat, acc2);
    n_checks++;
    if (acc2 - acc1 != DP_LAT + 3) begin
      n_fail++;
      $display("FAIL issue_interval: got %0d required %0d", acc2 - acc1, DP_LAT + 3);
    end
  endtask

  task automatic test_random();
    logic [63:0] res, s1, s2;
    int lat, acc;
    logic [1:0] op;
    logic w;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      w  = ($urandom_range(0, 3) == 0);
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: s1 = '0;
        1: s1 = '1;
        2: s2 = '0;
        3: s2 = '1;
        default: ;
      endcase
      run_op(op, w, s1, s2, $urandom_range(0, 2), res, lat, acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_mul_basic();
    test_mulh_variants();
    test_mulw();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_zero();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
